// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the load/store memory access controller.
// Opcodes, funct3 encodings, FSM states, error codes and request decode helpers.
package mem_ctrl_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE,
    ST_ERR
  } state_t;

  typedef struct packed {
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    if (store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Access size lives in funct3[1:0]; only legal encodings reach this check.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] offset);
    case (f3[1:0])
      2'b01:   return offset[0];
      2'b10:   return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational byte-lane logic: byte enables, store data replication,
// load lane selection with sign/zero extension.
module mem_lsu_align
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] ldata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata[{offset, 3'b000} +: 8];
  assign lane_h = rdata[{offset[1], 4'b0000} +: 16];

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << offset;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ldata = rdata;
    case (funct3)
      F3_B:    ldata = {{24{lane_b[7]}}, lane_b};
      F3_BU:   ldata = {24'b0, lane_b};
      F3_H:    ldata = {{16{lane_h[15]}}, lane_h};
      F3_HU:   ldata = {16'b0, lane_h};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store memory access controller: one outstanding access, wait-state
// tolerant with a bounded timeout, single-cycle done/error reporting.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic        cs,
  output logic        rd_n,
  output logic        wr_n,
  output logic [3:0]  be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] ldata_o,
  output logic [1:0]  err_o
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_d;
  req_t        req_q, req_d;
  logic [7:0]  cnt, cnt_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] ldata_q;
  logic        ld_cap;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_mem, is_store;
  logic [7:0]  cnt_inc;
  logic [3:0]  be_raw;
  logic [31:0] ldata_ext;
  logic        unused_inst;

  assign opcode      = inst_i[6:0];
  assign funct3      = inst_i[14:12];
  assign unused_inst = ^{inst_i[31:15], inst_i[11:7]};
  assign is_store    = (opcode == OP_STORE);
  assign is_mem      = req_i && ((opcode == OP_LOAD) || is_store);
  assign cnt_inc     = cnt + 8'd1;

  mem_lsu_align u_align (
    .funct3    (req_q.funct3),
    .offset    (req_q.addr[1:0]),
    .wdata     (req_q.wdata),
    .rdata     (mem_rdata),
    .be        (be_raw),
    .wdata_rep (mem_wdata),
    .ldata     (ldata_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      req_q   <= '0;
      cnt     <= '0;
      err_q   <= ERR_NONE;
      ldata_q <= '0;
    end else begin
      state <= state_d;
      req_q <= req_d;
      cnt   <= cnt_d;
      err_q <= err_d;
      if (ld_cap) ldata_q <= ldata_ext;
    end
  end

  always_comb begin
    state_d = state;
    req_d   = req_q;
    cnt_d   = cnt;
    err_d   = err_q;
    ld_cap  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_mem) begin
          req_d = '{store: is_store, funct3: funct3, addr: addr_i, wdata: wdata_i};
          cnt_d = '0;
          if (!f3_legal(is_store, funct3)) begin
            state_d = ST_ERR;
            err_d   = ERR_ILLEGAL;
          end else if (misaligned(funct3, addr_i[1:0])) begin
            state_d = ST_ERR;
            err_d   = ERR_MISALIGN;
          end else begin
            state_d = ST_ACCESS;
            err_d   = ERR_NONE;
          end
        end
      end
      ST_ACCESS: begin
        // An acknowledge always beats the timeout, even in the last counted cycle.
        if (mem_valid) begin
          state_d = ST_DONE;
          ld_cap  = !req_q.store;
        end else if (cnt_inc == CNT_LAST) begin
          state_d = ST_ERR;
          err_d   = ERR_TIMEOUT;
          cnt_d   = cnt_inc;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes decode straight from the state so an async reset drops them at once.
  assign cs       = (state == ST_ACCESS);
  assign rd_n     = !(cs && !req_q.store);
  assign wr_n     = !(cs && req_q.store);
  assign be       = cs ? be_raw : 4'b0000;
  assign mem_addr = {req_q.addr[31:2], 2'b00};
  assign busy_o   = (state != ST_IDLE);
  assign done_o   = (state == ST_DONE);
  assign err_o    = (state == ST_ERR) ? err_q : ERR_NONE;
  assign ldata_o  = ldata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: completions are predicted into a
// scoreboard queue at issue time and popped when done_o/err_o fire.
module tb_mem_access_ctrl;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic [31:0] inst_i = '0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        cs, rd_n, wr_n, busy_o, done_o;
  logic [3:0]  be;
  logic [31:0] mem_addr, mem_wdata, ldata_o;
  logic [1:0]  err_o;

  typedef struct {
    logic [1:0]  err;
    logic [31:0] ldata;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] ldata_model = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_acc;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .inst_i(inst_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .mem_valid(mem_valid), .mem_rdata(mem_rdata), .cs(cs),
    .rd_n(rd_n), .wr_n(wr_n), .be(be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy_o(busy_o), .done_o(done_o), .ldata_o(ldata_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    return {17'b0, f3, 5'b0, op};
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * a[1:0]);
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'b0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'b0, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  // Scoreboard consumer: every done/err pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (rst_n && (done_o || err_o != 2'b00)) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {29'b0, done_o, err_o}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("err_code", {30'b0, err_o}, {30'b0, mon_e.err});
        chk("done_pulse", {31'b0, done_o}, {31'b0, (mon_e.err == 2'b00)});
        if (mon_e.err == 2'b00) chk("ldata", ldata_o, mon_e.ldata);
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic mem_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd);
    logic store;
    store = (op == ST);
    if (!store) ldata_model = model_load(f3, a, rd);
    sb.push_back('{err: 2'b00, ldata: ldata_model});
    req_i = 1'b1; inst_i = mk(op, f3); addr_i = a; wdata_i = wd;
    @(posedge clk); #1;
    req_i = 1'b0; mem_valid = 1'b1; mem_rdata = rd;
    @(negedge clk);
    chk({tag, "_cs"}, {31'b0, cs}, 32'd1);
    chk({tag, "_rd_n"}, {31'b0, rd_n}, {31'b0, store});
    chk({tag, "_wr_n"}, {31'b0, wr_n}, {31'b0, !store});
    chk({tag, "_be"}, {28'b0, be}, {28'b0, exp_be});
    chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    if (store) chk({tag, "_wdata"}, mem_wdata, exp_wd);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_done_lat"}, {31'b0, done_o}, 32'd1);
    chk({tag, "_cs_off"}, {31'b0, cs}, 32'd0);
    chk({tag, "_busy_done"}, {31'b0, busy_o}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_busy_idle"}, {31'b0, busy_o}, 32'd0);
  endtask

  task automatic err_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [1:0] code);
    sb.push_back('{err: code, ldata: 32'h0});
    req_i = 1'b1; inst_i = mk(op, f3); addr_i = a;
    @(posedge clk); #1;
    req_i = 1'b0;
    @(negedge clk);
    chk({tag, "_no_cs"}, {27'b0, cs, be}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy_o}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_idle"}, {31'b0, busy_o}, 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_strobes", {26'b0, cs, rd_n, wr_n, be}, {26'b0, 3'b011, 4'b0000});
    chk("rst_status", {28'b0, busy_o, done_o, err_o}, 32'd0);
    chk("rst_ldata", ldata_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    mem_op("lw", LD, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 4'b1111, 32'h0);
    mem_op("lb", LD, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 4'b1000, 32'h0);
    mem_op("lbu", LD, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 4'b1000, 32'h0);
    mem_op("sh", ST, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 4'b1100, 32'hABCDABCD);
    mem_op("sb", ST, 3'b000, 32'h101, 32'h00000012, 32'h0, 4'b0010, 32'h12121212);
    mem_op("lh", LD, 3'b001, 32'h102, 32'h0, 32'h80011234, 4'b1100, 32'h0);
    mem_op("lhu", LD, 3'b101, 32'h000, 32'h0, 32'h12349ABC, 4'b0011, 32'h0);
    mem_op("lh0", LD, 3'b001, 32'h000, 32'h0, 32'h12349ABC, 4'b0011, 32'h0);

    err_op("lw_mis", LD, 3'b010, 32'h101, 2'b01);
    err_op("lh_mis", LD, 3'b001, 32'h103, 2'b01);
    err_op("sw_mis", ST, 3'b010, 32'h102, 2'b01);
    err_op("ld_f3_011", LD, 3'b011, 32'h100, 2'b11);
    err_op("st_f3_100", ST, 3'b100, 32'h100, 2'b11);

    // Non-memory opcode with a stray acknowledge: nothing may happen.
    req_i = 1'b1; inst_i = mk(7'b0110011, 3'b000); mem_valid = 1'b1;
    @(posedge clk); #1;
    req_i = 1'b0;
    @(negedge clk);
    chk("nonmem_idle", {30'b0, busy_o, cs}, 32'd0);
    @(posedge clk); #1;
    mem_valid = 1'b0;

    // Timeout: no acknowledge ever.
    sb.push_back('{err: 2'b10, ldata: 32'h0});
    req_i = 1'b1; inst_i = mk(LD, 3'b010); addr_i = 32'h200;
    @(posedge clk); #1;
    req_i = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!cs) break;
      n_acc++;
    end
    chk("timeout_cycles", n_acc, 32'd15);
    chk("timeout_strobes", {27'b0, rd_n, be}, {27'b0, 1'b1, 4'b0000});
    @(posedge clk); #1;
    chk("timeout_busy", {31'b0, busy_o}, 32'd0);

    // Acknowledge in the final counted cycle wins over the timeout.
    ldata_model = 32'h5A5A0001;
    sb.push_back('{err: 2'b00, ldata: ldata_model});
    req_i = 1'b1; inst_i = mk(LD, 3'b010); addr_i = 32'h204;
    @(posedge clk); #1;
    req_i = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    mem_valid = 1'b1; mem_rdata = 32'h5A5A0001;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(negedge clk);
    chk("late_ack_done", {31'b0, done_o}, 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an access.
    req_i = 1'b1; inst_i = mk(LD, 3'b010); addr_i = 32'h300;
    @(posedge clk); #1;
    req_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_cs", {31'b0, cs}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_strobes", {30'b0, cs, rd_n}, 32'd1);
    chk("rst_mid_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_mid_ldata", ldata_o, 32'd0);
    ldata_model = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_op("sw_post_rst", ST, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 4'b1111, 32'hCAFEF00D);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
